// File: rtl/sram_host_adapter_if.sv
// Signal bundle between a host, the sram_host_adapter and one RAM port.
// The slave modport is the adapter's view and the master modport is the host/RAM side.
interface sram_host_adapter_if #(
  parameter int Width = 32,
  parameter int Depth = 128
);
  localparam int Aw = $clog2(Depth);

  logic             req_i;
  logic             gnt_o;
  logic             we_i;
  logic [Width/8-1:0] be_i;
  logic [31:0]      addr_i;
  logic [Width-1:0] wdata_i;
  logic             rvalid_o;
  logic             rready_i;
  logic [Width-1:0] rdata_o;
  logic             err_o;
  logic             ram_req_o;
  logic             ram_write_o;
  logic [Aw-1:0]    ram_addr_o;
  logic [Width-1:0] ram_wdata_o;
  logic [Width-1:0] ram_wmask_o;
  logic [Width-1:0] ram_rdata_i;

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i, rready_i, ram_rdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o
  );

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, rready_i, ram_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o
  );
endinterface

// File: rtl/sram_host_adapter.sv
// Host front-end for one SRAM port: byte-enable to bit-mask conversion, read-latency
// hiding through a one-deep stage register, and an in-order response FIFO with credit-based grant.
module sram_host_adapter #(
  parameter int Width    = 32,
  parameter int Depth    = 128,
  parameter int RspDepth = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  sram_host_adapter_if.slave bus
);
  localparam int Aw = $clog2(Depth);
  localparam int Bw = $clog2(Width/8);
  localparam int Cw = $clog2(RspDepth+1);
  localparam int Pw = $clog2(RspDepth);
  localparam logic [Cw:0] CreditMax = (Cw+1)'(RspDepth);

  typedef struct packed {
    logic             err;
    logic [Width-1:0] rdata;
  } rsp_t;

  logic [31:0]   w_widx;
  logic          w_oob;
  logic          w_credit_ok;
  logic          w_gnt;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  rsp_t          w_push_data;
  rsp_t          w_head;

  logic          r_inflight;
  logic          r_st_we;
  logic          r_st_oob;
  logic [Cw-1:0] r_count;
  logic [Pw-1:0] r_wptr;
  logic [Pw-1:0] r_rptr;
  rsp_t          r_fifo [RspDepth];

  function automatic logic [Pw-1:0] ptr_inc(input logic [Pw-1:0] p);
    return (p == Pw'(RspDepth-1)) ? '0 : p + 1'b1;
  endfunction

  assign w_widx = bus.addr_i >> Bw;
  assign w_oob  = (w_widx >= 32'(Depth));

  // Credit counts the in-flight slot as well as stored entries; a same-cycle pop is ignored
  // so that rready_i never reaches gnt_o combinationally.
  assign w_credit_ok = ({{Cw{1'b0}}, r_inflight} + {1'b0, r_count}) < CreditMax;
  assign w_gnt       = bus.req_i & w_credit_ok & ~rst_i;
  assign w_accept    = bus.req_i & w_gnt;
  assign bus.gnt_o   = w_gnt;

  assign bus.ram_req_o   = w_accept & ~w_oob;
  assign bus.ram_write_o = bus.ram_req_o & bus.we_i;
  assign bus.ram_addr_o  = w_widx[Aw-1:0];
  assign bus.ram_wdata_o = bus.wdata_i;

  for (genvar gi = 0; gi < Width/8; gi++) begin : g_mask
    assign bus.ram_wmask_o[8*gi +: 8] = {8{bus.be_i[gi]}};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inflight <= 1'b0;
      r_st_we    <= 1'b0;
      r_st_oob   <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_st_we  <= bus.we_i;
        r_st_oob <= w_oob;
      end
    end
  end

  // RAM read data is only meaningful for an in-range read; everything else responds with zero.
  assign w_push            = r_inflight;
  assign w_push_data.err   = r_st_oob;
  assign w_push_data.rdata = (!r_st_we && !r_st_oob) ? bus.ram_rdata_i : '0;
  assign w_pop             = (r_count != '0) & bus.rready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_push_data;
  end

  assign w_head       = r_fifo[r_rptr];
  assign bus.rvalid_o = (r_count != '0);
  assign bus.rdata_o  = bus.rvalid_o ? w_head.rdata : '0;
  assign bus.err_o    = bus.rvalid_o ? w_head.err : 1'b0;
endmodule
